bk_sector_seq: RTL and testbench

Backup-RAM sector sequencer for the Genesis core. It sits between the hps_io SD-block interface (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`) and the cartridge backup RAM, which is addressed by `{sd_lba[6:0], sd_buff_addr}`. It decides when a save file is usable and sequences multi-sector loads and saves, including the automatic load after a ROM download. It also tracks unsaved changes for autosave and drives the LED-pending indication.

---
 rtl/bk_seq_pkg.sv | 14 +
 rtl/bk_sector_seq_if.sv | 15 +
 rtl/bk_edge_det.sv | 32 +++
 rtl/bk_sector_seq.sv | 196 +++++++++++++++++++
 tb/tb_bk_sector_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bk_seq_pkg.sv
// Backup-RAM sector sequencer: shared types and widths.
//   bk_state_t  : sequencer FSM state
//   BK_LBA_W    : live sector-number width (sd_lba[6:0])
//   BK_SD_LBA_W : full hps_io sd_lba width
//   BK_TMO_W    : ack timeout counter width
package bk_seq_pkg;

  typedef enum logic [1:0] {BK_IDLE, BK_REQ, BK_XFER} bk_state_t;

  localparam int unsigned BK_LBA_W    = 7;
  localparam int unsigned BK_SD_LBA_W = 32;
  localparam int unsigned BK_TMO_W    = 24;

endpackage

// File: rtl/bk_sector_seq_if.sv
// hps_io SD-block handshake between the backup-RAM sequencer and hps_io.
//   master (sequencer): drives sd_lba, sd_rd, sd_wr; receives sd_ack
//   slave  (hps_io)   : receives sd_lba, sd_rd, sd_wr; drives sd_ack
interface bk_sector_seq_if;
  import bk_seq_pkg::*;

  logic [BK_SD_LBA_W-1:0] sd_lba;
  logic                   sd_rd;
  logic                   sd_wr;
  logic                   sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);

endinterface

// File: rtl/bk_edge_det.sv
// Registered 1-bit rise/fall detector with synchronous active-high reset.
//   clk_i, rst_i : clock, synchronous reset
//   d_i          : level to watch
//   rise_o/fall_o: one-cycle pulse, one edge after the level change is sampled
module bk_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= d_i;
      rise_q <= d_i & ~prev_q;
      fall_q <= ~d_i & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/bk_sector_seq.sv
// Backup-RAM sector sequencer: decides when a save image is usable and runs
// multi-sector loads/saves over the hps_io SD-block handshake, including the
// automatic load after a ROM download; tracks unsaved changes for the LED.
// Optional feature macro: BK_AUTOSAVE_EN (autosave when the OSD opens).
// Ports:
//   clk_sys, reset                 : clock, synchronous active-high reset
//   dl_active, img_mounted,
//   img_readonly, img_size_nz      : download / save-image status
//   load_req, save_req             : OSD level requests (rising edge acts)
//   autosave_en, osd_open          : autosave option, OSD visible
//   bram_change                    : cart wrote backup RAM (pulse)
//   sd                             : hps_io sector handshake (master)
//   bk_ena, bk_loading, bk_busy,
//   sav_pending, bk_err            : status outputs
module bk_sector_seq
  import bk_seq_pkg::*;
#(
  parameter int unsigned SECTORS     = 128,
  parameter int unsigned ACK_TIMEOUT = 24'hFFFFFF
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            dl_active,
  input  logic            img_mounted,
  input  logic            img_readonly,
  input  logic            img_size_nz,
  input  logic            load_req,
  input  logic            save_req,
  input  logic            autosave_en,
  input  logic            osd_open,
  input  logic            bram_change,
  bk_sector_seq_if.master sd,
  output logic            bk_ena,
  output logic            bk_loading,
  output logic            bk_busy,
  output logic            sav_pending,
  output logic            bk_err
);

  localparam logic [BK_LBA_W-1:0] LAST_LBA = BK_LBA_W'(SECTORS - 1);
  localparam logic [BK_TMO_W-1:0] TMO_MAX  = BK_TMO_W'(ACK_TIMEOUT);

  bk_state_t             state_q, state_d;
  logic [BK_LBA_W-1:0]   lba_q, lba_d;
  logic [BK_TMO_W-1:0]   tmo_q, tmo_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  loading_q, loading_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  ena_q, ena_d;
  logic                  pend_q, pend_d;

  logic load_rise, save_rise, dl_rise, dl_fall, ack_rise, ack_fall;
  logic load_fall_unused, save_fall_unused;
  logic save_trig;
  logic auto_load_c, load_go_c, save_go_c, tmo_hit_c, is_load_c;

  bk_edge_det u_load_ed (.clk_i(clk_sys), .rst_i(reset), .d_i(load_req),
                         .rise_o(load_rise), .fall_o(load_fall_unused));
  bk_edge_det u_save_ed (.clk_i(clk_sys), .rst_i(reset), .d_i(save_req),
                         .rise_o(save_rise), .fall_o(save_fall_unused));
  bk_edge_det u_dl_ed   (.clk_i(clk_sys), .rst_i(reset), .d_i(dl_active),
                         .rise_o(dl_rise), .fall_o(dl_fall));
  bk_edge_det u_ack_ed  (.clk_i(clk_sys), .rst_i(reset), .d_i(sd.sd_ack),
                         .rise_o(ack_rise), .fall_o(ack_fall));

`ifdef BK_AUTOSAVE_EN
  // Level-sensitive autosave request, registered so it lines up with the edge triggers.
  logic auto_q;
  always_ff @(posedge clk_sys) begin
    if (reset) auto_q <= 1'b0;
    else       auto_q <= pend_q & osd_open & autosave_en;
  end
  assign save_trig = save_rise | auto_q;
`else
  logic autosave_unused;
  assign autosave_unused = autosave_en;
  assign save_trig       = save_rise;
`endif

  // Trigger qualification; load outranks save when both arrive together.
  assign auto_load_c = dl_fall & ena_q & img_size_nz;
  assign load_go_c   = load_rise & ena_q;
  assign save_go_c   = save_trig & ena_q;
  assign tmo_hit_c   = (ACK_TIMEOUT != 0) && (state_q != BK_IDLE) && (tmo_q == TMO_MAX);

  // State register and all registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= BK_IDLE;
      lba_q     <= '0;
      tmo_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      loading_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      ena_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      tmo_q     <= tmo_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      loading_q <= loading_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      ena_q     <= ena_d;
      pend_q    <= pend_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    err_d     = 1'b0;
    ena_d     = ena_q;
    pend_d    = pend_q;
    is_load_c = auto_load_c | load_go_c;

    if (tmo_hit_c) begin
      // hps_io stopped answering: drop the request, keep sd_lba for debug.
      state_d   = BK_IDLE;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      loading_d = 1'b0;
      err_d     = 1'b1;
    end else begin
      case (state_q)
        BK_IDLE: begin
          if (is_load_c | save_go_c) begin
            state_d   = BK_REQ;
            lba_d     = '0;
            loading_d = is_load_c;
            rd_d      = is_load_c;
            wr_d      = ~is_load_c;
          end
        end
        BK_REQ: begin
          if (ack_rise) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = BK_XFER;
          end
        end
        BK_XFER: begin
          if (ack_fall) begin
            if (lba_q == LAST_LBA) begin
              loading_d = 1'b0;
              state_d   = BK_IDLE;
            end else begin
              lba_d   = lba_q + BK_LBA_W'(1);
              rd_d    = loading_q;
              wr_d    = ~loading_q;
              state_d = BK_REQ;
            end
          end
        end
        default: begin
          state_d   = BK_IDLE;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          loading_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != BK_IDLE);
    // Per-edge watchdog: restarts whenever the state changes.
    tmo_d  = (busy_d && (state_d == state_q)) ? tmo_q + BK_TMO_W'(1) : '0;

    // A fresh download invalidates the image until it is mounted again.
    if (dl_rise) ena_d = 1'b0;
    if (dl_active & img_mounted & ~img_readonly) ena_d = 1'b1;

    // A new change wins over the clear caused by an ongoing transfer.
    if (busy_q) pend_d = 1'b0;
    if (bram_change & ~osd_open) pend_d = 1'b1;
  end

  assign sd.sd_lba   = BK_SD_LBA_W'(lba_q);
  assign sd.sd_rd    = rd_q;
  assign sd.sd_wr    = wr_q;
  assign bk_ena      = ena_q;
  assign bk_loading  = loading_q;
  assign bk_busy     = busy_q;
  assign sav_pending = pend_q;
  assign bk_err      = err_q;

endmodule

// File: tb/tb_bk_sector_seq.sv
// Directed + randomized bench for bk_sector_seq acting as the hps_io side.
module tb_bk_sector_seq;

  localparam int unsigned S  = 8;
  localparam int unsigned TO = 16;

  logic clk_sys = 1'b0;
  logic reset, dl_active, img_mounted, img_readonly, img_size_nz;
  logic load_req, save_req, autosave_en, osd_open, bram_change;
  logic bk_ena, bk_loading, bk_busy, sav_pending, bk_err;

  int total = 0;
  int bad   = 0;

  bk_sector_seq_if sd_if ();

  bk_sector_seq #(.SECTORS(S), .ACK_TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active),
    .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size_nz(img_size_nz), .load_req(load_req), .save_req(save_req),
    .autosave_en(autosave_en), .osd_open(osd_open),
    .bram_change(bram_change), .sd(sd_if), .bk_ena(bk_ena),
    .bk_loading(bk_loading), .bk_busy(bk_busy), .sav_pending(sav_pending),
    .bk_err(bk_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_rd"}, sd_if.sd_rd, 1'b0);
    chk1({tag, "_wr"}, sd_if.sd_wr, 1'b0);
    chk32({tag, "_lba"}, sd_if.sd_lba, 32'd0);
    chk1({tag, "_ena"}, bk_ena, 1'b0);
    chk1({tag, "_loading"}, bk_loading, 1'b0);
    chk1({tag, "_busy"}, bk_busy, 1'b0);
    chk1({tag, "_pend"}, sav_pending, 1'b0);
    chk1({tag, "_err"}, bk_err, 1'b0);
  endtask

  // Trigger applied just before: nothing one edge later, transfer two edges later.
  task automatic start_check(input string tag);
    tick();
    chk1({tag, "_not_yet"}, bk_busy | sd_if.sd_rd | sd_if.sd_wr, 1'b0);
    tick();
    chk1({tag, "_started"}, bk_busy, 1'b1);
  endtask

  // Serve one sector as hps_io with random ack timing.
  task automatic do_sector(input logic exp_rd, input int idx, input bit last);
    int d;
    chk1("req_rd", sd_if.sd_rd, exp_rd);
    chk1("req_wr", sd_if.sd_wr, ~exp_rd);
    chk32("req_lba", sd_if.sd_lba, 32'(idx));
    chk1("req_loading", bk_loading, exp_rd);
    d = int'($urandom_range(0, 3));
    repeat (d) tick();
    chk1("req_hold", sd_if.sd_rd | sd_if.sd_wr, 1'b1);
    sd_if.sd_ack = 1'b1;
    tick();
    chk1("req_until_ack", sd_if.sd_rd | sd_if.sd_wr, 1'b1);
    tick();
    chk1("req_drop", sd_if.sd_rd | sd_if.sd_wr, 1'b0);
    d = int'($urandom_range(0, 2));
    repeat (d) tick();
    chk1("xfer_busy", bk_busy, 1'b1);
    sd_if.sd_ack = 1'b0;
    tick();
    chk1("next_not_early", sd_if.sd_rd | sd_if.sd_wr, 1'b0);
    tick();
    if (last) begin
      chk1("done_busy", bk_busy, 1'b0);
      chk1("done_loading", bk_loading, 1'b0);
      chk1("done_req", sd_if.sd_rd | sd_if.sd_wr, 1'b0);
    end
  endtask

  task automatic run_xfer(input logic exp_rd);
    for (int i = 0; i < int'(S); i++) do_sector(exp_rd, i, i == int'(S) - 1);
  endtask

  // Writable mount during a download; leaves dl_active high.
  task automatic mount(input logic size_nz);
    img_readonly = 1'b0;
    img_size_nz  = size_nz;
    dl_active    = 1'b1;
    repeat (3) tick();
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    tick();
    chk1("mount_ena", bk_ena, 1'b1);
  endtask

  initial begin
    int op, errs, err_at;
    reset = 1'b1; dl_active = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
    img_size_nz = 1'b0; load_req = 1'b0; save_req = 1'b0; autosave_en = 1'b0;
    osd_open = 1'b0; bram_change = 1'b0; sd_if.sd_ack = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Auto-load after a download with a non-empty writable image.
    mount(1'b1);
    dl_active = 1'b0;
    start_check("autoload");
    run_xfer(1'b1);

    // Change while OSD open is ignored; with OSD closed it is pending.
    osd_open = 1'b1; bram_change = 1'b1; tick();
    bram_change = 1'b0; osd_open = 1'b0; tick();
    chk1("pend_osd_open", sav_pending, 1'b0);
    bram_change = 1'b1; tick();
    bram_change = 1'b0;
    chk1("pend_set", sav_pending, 1'b1);

    // Manual save; mid-transfer change and dropped load edge.
    save_req = 1'b1;
    start_check("save");
    do_sector(1'b0, 0, 1'b0);
    do_sector(1'b0, 1, 1'b0);
    chk1("pend_cleared_busy", sav_pending, 1'b0);
    bram_change = 1'b1; load_req = 1'b1; tick();
    bram_change = 1'b0;
    chk1("pend_set_wins", sav_pending, 1'b1);
    tick();
    chk1("pend_busy_clear", sav_pending, 1'b0);
    for (int i = 2; i < int'(S); i++) do_sector(1'b0, i, i == int'(S) - 1);
    repeat (4) tick();
    chk1("dropped_load", bk_busy, 1'b0);
    load_req = 1'b0; save_req = 1'b0; tick();

    // Load and save together: load wins.
    load_req = 1'b1; save_req = 1'b1;
    start_check("both");
    run_xfer(1'b1);
    load_req = 1'b0; save_req = 1'b0; tick();

    // Randomized load/save rounds.
    for (int r = 0; r < 4; r++) begin
      op = int'($urandom_range(0, 1));
      if (op == 1) load_req = 1'b1; else save_req = 1'b1;
      start_check("rand");
      run_xfer(op == 1);
      load_req = 1'b0; save_req = 1'b0;
      repeat (int'($urandom_range(1, 3))) tick();
    end

    // New download invalidates the image; empty image gives no auto-load.
    dl_active = 1'b1;
    repeat (3) tick();
    chk1("dl_clears_ena", bk_ena, 1'b0);
    dl_active = 1'b0;
    repeat (3) tick();
    chk1("no_autoload_ena0", bk_busy, 1'b0);
    mount(1'b0);
    dl_active = 1'b0;
    repeat (3) tick();
    chk1("no_autoload_size0", bk_busy, 1'b0);

    // Autosave when the OSD opens with pending changes.
    bram_change = 1'b1; tick();
    bram_change = 1'b0;
    chk1("auto_pend", sav_pending, 1'b1);
    osd_open = 1'b1; autosave_en = 1'b1;
`ifdef BK_AUTOSAVE_EN
    start_check("autosave");
    run_xfer(1'b0);
    chk1("autosave_pend", sav_pending, 1'b0);
`else
    repeat (4) tick();
    chk1("no_autosave", bk_busy, 1'b0);
    chk1("no_autosave_pend", sav_pending, 1'b1);
`endif
    osd_open = 1'b0; autosave_en = 1'b0; tick();

    // Ack never arrives: abort with one error pulse.
    load_req = 1'b1;
    start_check("tmo");
    chk1("tmo_rd", sd_if.sd_rd, 1'b1);
    errs = 0; err_at = -1;
    for (int k = 1; k <= int'(TO) + 5; k++) begin
      tick();
      if (bk_err) begin
        errs++;
        if (err_at < 0) err_at = k;
      end
    end
    chk32("tmo_pulses", 32'(errs), 32'd1);
    chk1("tmo_window", (err_at >= int'(TO)) && (err_at <= int'(TO) + 2), 1'b1);
    chk1("tmo_rd_clr", sd_if.sd_rd, 1'b0);
    chk1("tmo_loading", bk_loading, 1'b0);
    chk1("tmo_busy", bk_busy, 1'b0);
    chk32("tmo_lba", sd_if.sd_lba, 32'd0);
    load_req = 1'b0;
    sd_if.sd_ack = 1'b1; repeat (2) tick();
    sd_if.sd_ack = 1'b0; repeat (3) tick();
    chk1("late_ack_ignored", bk_busy | sd_if.sd_rd | sd_if.sd_wr, 1'b0);

    // Reset during XFER at LBA 5.
    save_req = 1'b1;
    start_check("rst_save");
    for (int i = 0; i < 5; i++) do_sector(1'b0, i, 1'b0);
    chk32("rst_at_lba5", sd_if.sd_lba, 32'd5);
    sd_if.sd_ack = 1'b1; repeat (2) tick();
    chk1("rst_in_xfer", bk_busy & ~sd_if.sd_wr, 1'b1);
    reset = 1'b1; save_req = 1'b0;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;
    sd_if.sd_ack = 1'b0;
    repeat (4) tick();
    chk1("post_rst_idle", bk_busy | sd_if.sd_rd | sd_if.sd_wr, 1'b0);

    // Read-only image: never enabled, load request ignored.
    img_readonly = 1'b1; img_size_nz = 1'b1; dl_active = 1'b1;
    repeat (3) tick();
    img_mounted = 1'b1; tick();
    img_mounted = 1'b0; tick();
    dl_active = 1'b0; repeat (3) tick();
    chk1("ro_ena", bk_ena, 1'b0);
    load_req = 1'b1; repeat (4) tick();
    chk1("ro_busy", bk_busy, 1'b0);
    chk1("ro_req", sd_if.sd_rd | sd_if.sd_wr, 1'b0);
    load_req = 1'b0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
